// File: rtl/child_result_collector.sv
`default_nettype none
// ============================================================================
// child_result_collector
//   Round-robin fan-in of NUM_CHILDREN result streams into one registered,
//   source-tagged output with a running accepted-transfer counter.
//   Revision: 1.0
// ============================================================================
module child_result_collector #(
   parameter int NUM_CHILDREN = 10,
   parameter int DATA_W       = 8,
   parameter int SRC_W        = 4,
   parameter int CNT_W        = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CHILDREN-1:0]        in_valid,
   input  logic [NUM_CHILDREN*DATA_W-1:0] in_data,
   output logic [NUM_CHILDREN-1:0]        in_ready,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [SRC_W-1:0]               out_src,
   input  logic                           out_ready,
   output logic [CNT_W-1:0]               xfer_count
);

   localparam logic [SRC_W-1:0] c_LAST = SRC_W'(NUM_CHILDREN - 1);
   localparam logic [SRC_W:0]   c_NUM  = (SRC_W + 1)'(NUM_CHILDREN);

   logic [SRC_W-1:0]  r_ptr;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [SRC_W-1:0]  r_out_src;
   logic [CNT_W-1:0]  r_count;

   logic [NUM_CHILDREN-1:0] w_rot;
   logic [SRC_W:0]          w_sum;
   logic [SRC_W-1:0]        w_grant;
   logic                    w_any;
   logic                    w_space;
   logic                    w_accept;
   logic [DATA_W-1:0]       w_payload [NUM_CHILDREN];

   // Rotate valids so bit 0 is the child at the pointer; first set bit wins.
   assign w_rot = NUM_CHILDREN'({in_valid, in_valid} >> r_ptr);

   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_sum   = '0;
      for (int k = 0; k < NUM_CHILDREN; k++) begin
         if (!w_any && w_rot[k]) begin
            w_any   = 1'b1;
            w_sum   = {1'b0, r_ptr} + (SRC_W + 1)'(k);
            w_grant = (w_sum >= c_NUM) ? SRC_W'(w_sum - c_NUM) : SRC_W'(w_sum);
         end
      end
   end

   assign w_space  = !r_out_valid || out_ready;
   assign w_accept = !rst && w_any && w_space;

   generate
      for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_chan
         assign w_payload[i] = in_data[i*DATA_W +: DATA_W];
         assign in_ready[i]  = w_accept && (w_grant == SRC_W'(i));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_count     <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_payload[w_grant];
         r_out_src   <= w_grant;
         r_ptr       <= (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
         r_count     <= r_count + 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_src    = r_out_src;
   assign xfer_count = r_count;

endmodule
`default_nettype wire

// File: doc/child_result_collector.md
# child_result_collector

Fan-in collector that merges the result streams of up to ten child instances into one registered output stream tagged with the source index. It uses round-robin arbitration with a one-entry output register and a running transfer counter. It is the upstream end of a parent's fan-out to ten children: the parent distributes work to `inst_0`…`inst_9`, and this block gathers their results back to the parent.

## Interface

**Parameters**
- `NUM_CHILDREN`, default 10: number of input channels (2..16).
- `DATA_W`, default 8: payload width per channel.
- `SRC_W`, default 4: source index width; must satisfy 2^SRC_W ≥ NUM_CHILDREN.
- `CNT_W`, default 16: transfer counter width.

**Ports** (one clock; reset is synchronous and active-high)
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, NUM_CHILDREN: per-child valid.
- `in_data`, in, NUM_CHILDREN*DATA_W: child i payload in bits [i*DATA_W +: DATA_W].
- `in_ready`, out, NUM_CHILDREN: per-child ready (combinational).
- `out_valid`, out, 1: output register holds a result.
- `out_data`, out, DATA_W: registered payload.
- `out_src`, out, SRC_W: index of the child that produced `out_data`.
- `out_ready`, in, 1: downstream accepts.
- `xfer_count`, out, CNT_W: number of accepted input transfers since reset.

## Operation

- **State:** round-robin pointer `ptr` (0..NUM_CHILDREN-1), output register (`out_valid`, `out_data`, `out_src`), `xfer_count`.
- **Grant:**
  - `g` is the first index i with `in_valid[i]`=1, searching ptr, ptr+1, …, NUM_CHILDREN-1, 0, …, ptr-1.
  - `any` = OR of `in_valid`.
- **Slot free:** `space` = !`out_valid` | `out_ready`.
- **Ready:**
  - `in_ready[i]` = !`rst` & `any` & `space` & (i == g).
  - At most one bit of `in_ready` is high in any cycle.
  - `in_ready` never depends on `in_valid[j]` for j ≠ g beyond grant selection.
- **Accept:** `in_valid[g]` & `in_ready[g]`. On the same edge:
  - `out_data` ← payload of g; `out_src` ← g; `out_valid` ← 1.
  - `ptr` ← g+1, or 0 if g = NUM_CHILDREN-1.
  - `xfer_count` ← `xfer_count`+1, wrapping modulo 2^CNT_W.
- **Drain:** when `out_valid` & `out_ready` & no accept, `out_valid` ← 0 and `out_data`/`out_src` hold their last values.
- **Simultaneous drain and accept:** the register is overwritten with the new entry and `out_valid` stays 1.
- **Idle:** no valid input leaves `ptr` unchanged.
- **Reset (any cycle, including mid-transfer):**
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, `xfer_count`=0.
  - The entry in flight is dropped.
  - `in_ready`=0 during the reset cycle, so no accept occurs.
- **Output stability:** while `out_valid` & !`out_ready`, `out_data` and `out_src` must not change and `in_ready` is all zero.
- **Input protocol:** children must keep `in_valid`/`in_data` stable until accepted. The collector does not check this; behaviour if violated is only that the currently presented value is taken.

## Timing

- Latency is 1 cycle: accept at edge k gives `out_valid`=1 with that data after edge k.
- Throughput is 1 transfer/cycle while `out_ready`=1 and any input is valid.
- Fairness: a continuously valid child is granted within NUM_CHILDREN accepts.
- `in_ready` is the only combinational output. Its path is `in_valid`/`out_valid`/`out_ready`/`ptr` → `in_ready`, with no path from `in_data`.
- `out_*` and `xfer_count` are registered.
- Deassertion of `rst` at edge k allows the first accept at edge k+1.

## Test plan

- **Single source.** Only child 3 valid, data 0xA5, `out_ready`=1.
  - `in_ready`=0x008; one cycle later `out_valid`=1, `out_data`=0xA5, `out_src`=3; `xfer_count`=1.
- **All valid, full throughput.** All ten children valid continuously, child i data = 0x10+i, `out_ready`=1.
  - `out_src` sequence 0,1,…,9,0,1 on consecutive cycles with matching data; `xfer_count`=12 after 12 cycles.
- **Backpressure.** Children 2 and 7 valid; `out_ready`=0 for 5 cycles after the first accept.
  - `out_src`=2 held stable and `in_ready`=0 for those 5 cycles.
  - Raising `out_ready` gives `out_src`=7 on the next cycle, with no gap and no duplicate.
- **Pointer wrap.** `ptr` at 9 after accepting child 8; children 9 and 1 valid.
  - Child 9 is granted, then child 1; `ptr` goes 9→0→2.
- **Reset mid-operation.** Assert `rst` for 1 cycle while `out_valid`=1 and `out_ready`=0.
  - Next cycle: `out_valid`=0, `out_src`=0, `xfer_count`=0, `in_ready`=0 during reset.
  - After reset the grant starts from child 0.
- **Counter wrap.** Run with CNT_W=4 for 17 accepts.
  - `xfer_count` reads 15 after accept 15, 0 after accept 16, 1 after accept 17.
